// File: rtl/param_updown_counter.sv
// Parametrised up/down counter: programmable terminal value, wrap/saturate, load/clear,
// terminal-count pulse and sticky overflow. Optional prescaler via PARAM_COUNTER_PRESCALE_EN.
module param_updown_counter #(
    parameter int WIDTH      = 8,
    parameter int MAX_COUNT  = 2**WIDTH-1,
    parameter int PRESCALE_W = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  en,
    input  logic                  dir,
    input  logic                  sat,
    input  logic                  clr,
    input  logic                  load,
    input  logic [WIDTH-1:0]      load_val,
    input  logic [PRESCALE_W-1:0] prescale,
    output logic [WIDTH-1:0]      count,
    output logic                  tc,
    output logic                  ovf,
    output logic                  at_max,
    output logic                  at_zero
);

    localparam logic [WIDTH-1:0] MAX_C = WIDTH'(MAX_COUNT);

    logic [WIDTH-1:0] count_reg;
    logic [WIDTH-1:0] step_next;
    logic [WIDTH-1:0] load_next;
    logic             tc_reg;
    logic             ovf_reg;
    logic             boundary;
    logic             tick;

`ifdef PARAM_COUNTER_PRESCALE_EN
    logic [PRESCALE_W-1:0] psc_reg;

    assign tick = (psc_reg == prescale);

    always_ff @(posedge clk) begin
        if (rst_n || clr || load) begin
            psc_reg <= '0;
        end else if (en) begin
            psc_reg <= tick ? '0 : psc_reg + 1'b1;
        end
    end
`else
    logic unused_prescale;

    assign unused_prescale = ^prescale;
    assign tick            = 1'b1;
`endif

    // Boundary is detected before any arithmetic so count+1 / count-1 never leave [0, MAX_C].
    always_comb begin
        boundary  = dir ? (count_reg == MAX_C) : (count_reg == '0);
        step_next = count_reg;
        if (dir) begin
            if (boundary) step_next = sat ? MAX_C : '0;
            else          step_next = count_reg + 1'b1;
        end else begin
            if (boundary) step_next = sat ? '0 : MAX_C;
            else          step_next = count_reg - 1'b1;
        end
        load_next = (load_val > MAX_C) ? MAX_C : load_val;
    end

    always_ff @(posedge clk) begin
        if (rst_n) begin
            count_reg <= '0;
            tc_reg    <= 1'b0;
            ovf_reg   <= 1'b0;
        end else if (clr) begin
            count_reg <= '0;
            tc_reg    <= 1'b0;
            ovf_reg   <= 1'b0;
        end else if (load) begin
            count_reg <= load_next;
            tc_reg    <= 1'b0;
        end else if (en && tick) begin
            count_reg <= step_next;
            tc_reg    <= boundary;
            if (boundary) ovf_reg <= 1'b1;
        end else begin
            tc_reg    <= 1'b0;
        end
    end

    assign count   = count_reg;
    assign tc      = tc_reg;
    assign ovf     = ovf_reg;
    assign at_max  = (count_reg == MAX_C);
    assign at_zero = (count_reg == '0);

endmodule

// File: tb/tb_param_updown_counter.sv
// Self-checking bench for param_updown_counter (WIDTH=4, MAX_COUNT=9): vector table plus
// hand-written wrap and prescaler sequences.
module tb_param_updown_counter;

    logic       clk;
    logic       rst_n;
    logic       en;
    logic       dir;
    logic       sat;
    logic       clr;
    logic       load;
    logic [3:0] load_val;
    logic [3:0] prescale;
    logic [3:0] count;
    logic       tc;
    logic       ovf;
    logic       at_max;
    logic       at_zero;

    int errors = 0;
    int checks = 0;

    param_updown_counter #(
        .WIDTH     (4),
        .MAX_COUNT (9),
        .PRESCALE_W(4)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .en      (en),
        .dir     (dir),
        .sat     (sat),
        .clr     (clr),
        .load    (load),
        .load_val(load_val),
        .prescale(prescale),
        .count   (count),
        .tc      (tc),
        .ovf     (ovf),
        .at_max  (at_max),
        .at_zero (at_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic       rst;
        logic       clr;
        logic       load;
        logic       en;
        logic       dir;
        logic       sat;
        logic [3:0] lv;
        logic [3:0] c;
        logic       tc;
        logic       ovf;
        logic       amax;
        logic       azero;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic r, input logic cl, input logic l, input logic e,
                                input logic d, input logic s, input logic [3:0] v,
                                input logic [3:0] c, input logic t, input logic o,
                                input logic am, input logic az);
        vec_t x;
        x = '{r, cl, l, e, d, s, v, c, t, o, am, az};
        return x;
    endfunction

    task automatic drive(input logic r, input logic cl, input logic l, input logic e,
                         input logic d, input logic s, input logic [3:0] v);
        rst_n    = r;
        clr      = cl;
        load     = l;
        en       = e;
        dir      = d;
        sat      = s;
        load_val = v;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input int idx, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s[%0d]: got %0d expected %0d", name, idx, act, exp);
        end
    endtask

    task automatic check_all(input int idx, input logic [3:0] c, input logic t, input logic o,
                             input logic am, input logic az);
        check("count", idx, int'(count), int'(c));
        check("tc", idx, int'(tc), int'(t));
        check("ovf", idx, int'(ovf), int'(o));
        check("at_max", idx, int'(at_max), int'(am));
        check("at_zero", idx, int'(at_zero), int'(az));
        $display("txn %0d: count=%0d tc=%0d ovf=%0d at_max=%0d at_zero=%0d",
                 idx, count, tc, ovf, at_max, at_zero);
    endtask

    initial begin
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0);
        prescale = 4'd0;

        // reset
        vecs.push_back(mk(1,0,0,0,0,0,4'd0,  4'd0,0,0,0,1));
        // count up with wrap: 1..9, 0, 1, 2
        for (int k = 1; k <= 9; k++)
            vecs.push_back(mk(0,0,0,1,1,0,4'd0, 4'(k),0,0,(k == 9),0));
        vecs.push_back(mk(0,0,0,1,1,0,4'd0,  4'd0,1,1,0,1));
        vecs.push_back(mk(0,0,0,1,1,0,4'd0,  4'd1,0,1,0,0));
        vecs.push_back(mk(0,0,0,1,1,0,4'd0,  4'd2,0,1,0,0));
        // hold
        vecs.push_back(mk(0,0,0,0,1,0,4'd0,  4'd2,0,1,0,0));
        // saturate at top
        vecs.push_back(mk(0,0,1,0,1,1,4'd8,  4'd8,0,1,0,0));
        vecs.push_back(mk(0,0,0,1,1,1,4'd0,  4'd9,0,1,1,0));
        vecs.push_back(mk(0,0,0,1,1,1,4'd0,  4'd9,1,1,1,0));
        vecs.push_back(mk(0,0,0,1,1,1,4'd0,  4'd9,1,1,1,0));
        vecs.push_back(mk(0,0,0,1,1,1,4'd0,  4'd9,1,1,1,0));
        // reset then count down with wrap
        vecs.push_back(mk(1,0,0,0,0,0,4'd0,  4'd0,0,0,0,1));
        vecs.push_back(mk(0,0,0,1,0,0,4'd0,  4'd9,1,1,1,0));
        vecs.push_back(mk(0,0,0,1,0,0,4'd0,  4'd8,0,1,0,0));
        // clamp, load beats en, clr beats load
        vecs.push_back(mk(0,0,1,0,1,0,4'd15, 4'd9,0,1,1,0));
        vecs.push_back(mk(0,0,1,1,1,0,4'd3,  4'd3,0,1,0,0));
        vecs.push_back(mk(0,1,1,0,1,0,4'd7,  4'd0,0,0,0,1));
        // saturate at bottom, repeated tc, then direction change
        vecs.push_back(mk(0,0,0,1,0,1,4'd0,  4'd0,1,1,0,1));
        vecs.push_back(mk(0,0,0,1,0,1,4'd0,  4'd0,1,1,0,1));
        vecs.push_back(mk(0,0,0,1,1,1,4'd0,  4'd1,0,1,0,0));
        // mid-count reset overrides en and load
        vecs.push_back(mk(0,0,1,0,1,0,4'd5,  4'd5,0,1,0,0));
        vecs.push_back(mk(1,0,1,1,1,0,4'd7,  4'd0,0,0,0,1));
        // clr beats en
        vecs.push_back(mk(0,0,1,0,1,0,4'd9,  4'd9,0,0,1,0));
        vecs.push_back(mk(0,0,0,1,1,0,4'd0,  4'd0,1,1,0,1));
        vecs.push_back(mk(0,1,0,1,1,0,4'd0,  4'd0,0,0,0,1));

        foreach (vecs[i]) begin
            drive(vecs[i].rst, vecs[i].clr, vecs[i].load, vecs[i].en,
                  vecs[i].dir, vecs[i].sat, vecs[i].lv);
            step();
            check_all(i, vecs[i].c, vecs[i].tc, vecs[i].ovf, vecs[i].amax, vecs[i].azero);
        end

        // full down sweep from 9, wrap back to 9, then single-cycle tc
        drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'd9);
        step();
        check_all(100, 4'd9, 0, 0, 1, 0);
        for (int i = 0; i < 9; i++) begin
            drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 4'd0);
            step();
            check_all(101 + i, 4'(8 - i), 0, 0, 0, (i == 8));
        end
        step();
        check_all(110, 4'd9, 1, 1, 1, 0);
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0);
        step();
        check_all(111, 4'd9, 0, 1, 1, 0);

`ifdef PARAM_COUNTER_PRESCALE_EN
        // step every 3rd enabled cycle; dropping en freezes prescaler and count
        drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 4'd0);
        prescale = 4'd2;
        step();
        check_all(200, 4'd0, 0, 0, 0, 1);
        for (int i = 0; i < 9; i++) begin
            drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 4'd0);
            step();
            check_all(201 + i, 4'((i + 1) / 3), 0, 0, 0, (i < 2));
        end
        step();
        check_all(210, 4'd3, 0, 0, 0, 0);
        step();
        check_all(211, 4'd3, 0, 0, 0, 0);
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 4'd0);
        step();
        check_all(212, 4'd3, 0, 0, 0, 0);
        step();
        check_all(213, 4'd3, 0, 0, 0, 0);
        drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 4'd0);
        step();
        check_all(214, 4'd4, 0, 0, 0, 0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/param_updown_counter.md
# param_updown_counter

Parametrised up/down counter with programmable terminal value, wrap or saturate mode, synchronous load/clear, terminal-count pulse, and sticky overflow flag. Generalises the 4-bit enable-only counter on the Tiny Tapeout user tile. The tile top drives `ui_in`/`uio_in` controls into this block and maps `count`/flags onto `uo_out`.

## Interface
Parameters:
- `WIDTH`, default 8: counter width in bits, minimum 2.
- `MAX_COUNT`, default 2**WIDTH-1: terminal (highest) count value; must be between 1 and 2**WIDTH-1.
- `PRESCALE_W`, default 4: prescaler compare width; used only with the macro in Configuration.

Ports:
- `clk` input 1: clock; all state updates on the rising edge.
- `rst_n` input 1: reset, synchronous and active-high; the name is kept for pin compatibility, and 1 means reset.
- `en` input 1: count enable.
- `dir` input 1: direction; 1 counts up, 0 counts down.
- `sat` input 1: boundary mode; 1 saturates, 0 wraps.
- `clr` input 1: synchronous clear of count, ovf, and prescaler.
- `load` input 1: synchronous load of `load_val`.
- `load_val` input WIDTH: load value.
- `prescale` input PRESCALE_W: tick divider, effective only with the macro.
- `count` output WIDTH: registered count value.
- `tc` output 1: registered terminal-count pulse, 1 cycle.
- `ovf` output 1: sticky flag, set on any boundary event.
- `at_max` output 1: combinational, `count == MAX_COUNT`.
- `at_zero` output 1: combinational, `count == 0`.

## Operation
- Reset values: count=0, tc=0, ovf=0, prescaler=0, at_zero=1, at_max=0.
- Per-cycle priority: rst_n > clr > load > step > hold.
- clr sets count=0 and ovf=0, zeroes the prescaler, and forces tc=0.
- load sets count=load_val, clamped to MAX_COUNT if larger. It zeroes the prescaler, forces tc=0, and leaves ovf unchanged.
- A step occurs when `en && tick`. Without the macro, tick is constant 1.
- Up step:
  - count<MAX_COUNT: count+1.
  - count==MAX_COUNT with sat=0: count wraps to 0.
  - count==MAX_COUNT with sat=1: count holds at MAX_COUNT.
  - Either boundary case sets tc=1 for that cycle and sets ovf=1.
- Down step:
  - count>0: count-1.
  - count==0 with sat=0: count wraps to MAX_COUNT.
  - count==0 with sat=1: count holds at 0.
  - Either boundary case sets tc=1 and ovf=1.
- In saturate mode, tc pulses on every attempted step at the boundary, not only the first.
- Cycles with no step: tc=0 and count holds.
- Arithmetic: all compares are WIDTH-bit unsigned. No intermediate value may exceed MAX_COUNT, including when MAX_COUNT=2**WIDTH-1 (no carry-out use).
- dir, sat, and load_val are sampled every cycle with no latching; a dir change takes effect on the next step.
- ovf stays set until clr or rst_n.

## Timing
- A step, load, or clear is visible on `count` one cycle after the edge where it is sampled. Latency is 1.
- `tc` is registered and aligned with the `count` update it describes.
- at_max and at_zero follow `count` combinationally with no extra cycle.
- rst_n asserted mid-operation takes effect on the next edge and overrides simultaneous load, clr, and en.
- load and en asserted in the same cycle: load wins, and no step or tc occurs.
- clr and load asserted in the same cycle: clr wins, and count=0.

## Configuration
- `PARAM_COUNTER_PRESCALE_EN` defined:
  - A PRESCALE_W-bit prescaler advances while en=1 and holds while en=0.
  - tick=1 when the prescaler equals `prescale`, and the prescaler then returns to 0. One step therefore occurs every `prescale`+1 enabled cycles.
  - prescale=0 gives a step every enabled cycle.
  - rst_n, clr, and load zero the prescaler.
  - A change to `prescale` applies at the next compare.
- Macro undefined: no prescaler logic is built, tick=1, and the `prescale` input is ignored. It stays a port but is unused.

## Test plan
Bench parameters: WIDTH=4, MAX_COUNT=9.
- Reset then en=1, dir=1, sat=0 for 12 cycles -> count goes 1..9, 0, 1, 2; tc=1 only in the cycle count goes 9->0; ovf=1 from then on.
- sat=1, dir=1, load_val=8 with load, then en=1 for 4 cycles -> count 9, 9, 9, 9; tc=1 on the last three cycles; at_max=1.
- From reset, dir=0, sat=0, en=1 for 2 cycles -> count 9, 8; tc=1 on the 0->9 wrap; at_zero=1 only before the first step.
- load_val=15 with load -> count=9 (clamp), tc=0. Then load and en together with load_val=3 -> count=3 with no step. Then clr together with load -> count=0, ovf=0.
- Mid-count (count=5) assert rst_n for 1 cycle while en=1 and load=1 -> count=0, tc=0, ovf=0 on the next cycle.
- Macro defined, prescale=2, en=1 for 9 cycles -> count increments every 3rd cycle, reaching 3. Dropping en holds both the prescaler and the count.
